router_pkt_gen: RTL

CSR-programmed hardware packet source for the router input port. It is the transmitting end of the `dut_inp`/`inp_valid` stream that the router consumes. The block builds framed packets (header, length, payload, checksum), honours the router's `busy` backpressure at packet boundaries, and counts router `error` pulses. It sits beside the router in the top level, so the router can be exercised without a testbench driver.

---
 rtl/router_pkg.sv | 28 ++
 rtl/router_pkt_gen_csr.sv | 66 ++++++
 rtl/router_pkt_gen.sv | 159 +++++++++++++++
 3 files changed

// File: rtl/router_pkg.sv
// Shared constants and types for the router packet generator: CSR map,
// register field positions, FSM state encoding and frame overhead.
package router_pkg;

  localparam logic [7:0] ADDR_CTRL    = 8'h00;
  localparam logic [7:0] ADDR_CFG     = 8'h04;
  localparam logic [7:0] ADDR_COUNT   = 8'h08;
  localparam logic [7:0] ADDR_STATUS  = 8'h0C;
  localparam logic [7:0] ADDR_ERR_CNT = 8'h10;

  localparam int CTRL_START_BIT     = 0;
  localparam int CTRL_ABORT_BIT     = 1;
  localparam int CFG_DEST_LSB       = 0;
  localparam int CFG_LEN_LSB        = 8;
  localparam int CFG_SEED_LSB       = 16;
  localparam int CFG_IPG_LSB        = 24;
  localparam int STATUS_ACTIVE_BIT  = 0;
  localparam int STATUS_CFG_ERR_BIT = 1;
  localparam int STATUS_PKTS_LSB    = 16;

  // Bytes framing every payload: dest, len and csum.
  localparam int PKT_OVERHEAD = 3;

  typedef enum logic [2:0] {
    IDLE, WAIT_RDY, HDR, LEN, PAYLOAD, CSUM, GAP
  } gen_state_t;

endpackage

// File: rtl/router_pkt_gen_csr.sv
// Register file for the packet generator: CFG/COUNT storage, registered read
// mux, start/abort strobes decoded from CTRL writes, and the error counter.
module router_pkt_gen_csr
  import router_pkg::*;
(
  input  logic        clk,
  input  logic        reset,
  input  logic        wr,
  input  logic        rd,
  input  logic [7:0]  addr,
  input  logic [31:0] wdata,
  output logic [31:0] rdata,
  input  logic        error,
  input  logic        active,
  input  logic        cfg_err,
  input  logic [15:0] pkts_sent,
  output logic        start_req,
  output logic        abort_req,
  output logic [31:0] cfg,
  output logic [15:0] count
);

  logic [15:0] err_cnt;
  logic        error_q;
  logic [31:0] rd_mux;

  // CTRL bits are strobes only; nothing is stored, so CTRL reads back 0.
  assign start_req = wr && (addr == ADDR_CTRL) && wdata[CTRL_START_BIT];
  assign abort_req = wr && (addr == ADDR_CTRL) && wdata[CTRL_ABORT_BIT];

  always_comb begin
    rd_mux = '0;
    case (addr)
      ADDR_CFG:     rd_mux = cfg;
      ADDR_COUNT:   rd_mux = {16'd0, count};
      ADDR_STATUS: begin
        rd_mux[STATUS_ACTIVE_BIT]        = active;
        rd_mux[STATUS_CFG_ERR_BIT]       = cfg_err;
        rd_mux[STATUS_PKTS_LSB +: 16]    = pkts_sent;
      end
      ADDR_ERR_CNT: rd_mux = {16'd0, err_cnt};
      default:      rd_mux = '0;
    endcase
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      cfg     <= '0;
      count   <= '0;
      err_cnt <= '0;
      error_q <= 1'b0;
      rdata   <= '0;
    end else begin
      error_q <= error;
      if (wr && addr == ADDR_CFG)   cfg   <= wdata;
      if (wr && addr == ADDR_COUNT) count <= wdata[15:0];
      // A clear in the same cycle as an error edge drops that edge.
      if (wr && addr == ADDR_ERR_CNT)
        err_cnt <= '0;
      else if (error && !error_q && err_cnt != 16'hFFFF)
        err_cnt <= err_cnt + 16'd1;
      if (rd) rdata <= rd_mux;
    end
  end

endmodule

// File: rtl/router_pkt_gen.sv
// CSR-programmed packet source for the router input port: frames
// dest/len/payload/csum packets, honours busy between packets, runs bursts.
module router_pkt_gen
  import router_pkg::*;
#(
  parameter int MAX_LEN = 255
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        wr,
  input  logic        rd,
  input  logic [7:0]  addr,
  input  logic [31:0] wdata,
  output logic [31:0] rdata,
  output logic [7:0]  dut_inp,
  output logic        inp_valid,
  input  logic        busy,
  input  logic        error,
  output logic        gen_done
);

  gen_state_t  state;
  logic [31:0] cfg;
  logic [15:0] count;
  logic [15:0] pkts_sent;
  logic        start_req, abort_req, cfg_err, abort_pend;
  logic [7:0]  pkt_len, pkt_seed, pkt_ipg, pay_cnt, gap_cnt, csum, pay_byte;
  logic [7:0]  cfg_dest, cfg_len, cfg_seed, cfg_ipg;
  logic        len_ok, last_pkt, launch;

  router_pkt_gen_csr u_csr (
    .clk       (clk),
    .reset     (reset),
    .wr        (wr),
    .rd        (rd),
    .addr      (addr),
    .wdata     (wdata),
    .rdata     (rdata),
    .error     (error),
    .active    (state != IDLE),
    .cfg_err   (cfg_err),
    .pkts_sent (pkts_sent),
    .start_req (start_req),
    .abort_req (abort_req),
    .cfg       (cfg),
    .count     (count)
  );

  assign cfg_dest = cfg[CFG_DEST_LSB +: 8];
  assign cfg_len  = cfg[CFG_LEN_LSB  +: 8];
  assign cfg_seed = cfg[CFG_SEED_LSB +: 8];
  assign cfg_ipg  = cfg[CFG_IPG_LSB  +: 8];

  assign len_ok   = (cfg_len != 8'd0) && (int'(cfg_len) <= MAX_LEN);
  assign last_pkt = (count != 16'd0) && (({1'b0, pkts_sent} + 17'd1) >= {1'b0, count});
  assign pay_byte = pkt_seed + pay_cnt;

  // The last gap cycle doubles as the ready check, so packets are spaced by
  // exactly max(ipg,1) idle cycles when busy is low; otherwise park in WAIT_RDY.
  assign launch = !abort_req && !busy &&
                  ((state == WAIT_RDY) || (state == GAP && gap_cnt <= 8'd1));

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state      <= IDLE;
      dut_inp    <= '0;
      inp_valid  <= 1'b0;
      gen_done   <= 1'b0;
      pkt_len    <= '0;
      pkt_seed   <= '0;
      pkt_ipg    <= '0;
      pay_cnt    <= '0;
      gap_cnt    <= '0;
      csum       <= '0;
      abort_pend <= 1'b0;
      cfg_err    <= 1'b0;
      pkts_sent  <= '0;
    end else begin
      gen_done <= 1'b0;
      if (launch) begin
        // CFG is snapshotted here; later writes affect the next packet.
        state     <= HDR;
        dut_inp   <= cfg_dest;
        inp_valid <= 1'b1;
        csum      <= cfg_dest;
        pkt_len   <= cfg_len;
        pkt_seed  <= cfg_seed;
        pkt_ipg   <= cfg_ipg;
      end else begin
        case (state)
          IDLE: begin
            if (start_req) begin
              if (len_ok) begin
                state      <= WAIT_RDY;
                cfg_err    <= 1'b0;
                pkts_sent  <= '0;
                abort_pend <= 1'b0;
              end else begin
                cfg_err <= 1'b1;
              end
            end
          end
          WAIT_RDY: if (abort_req) state <= IDLE;
          HDR: begin
            state   <= LEN;
            dut_inp <= pkt_len;
            csum    <= csum ^ pkt_len;
          end
          LEN: begin
            if (pkt_len == 8'd0) begin
              state   <= CSUM;
              dut_inp <= csum;
            end else begin
              state   <= PAYLOAD;
              dut_inp <= pkt_seed;
              csum    <= csum ^ pkt_seed;
              pay_cnt <= 8'd1;
            end
          end
          PAYLOAD: begin
            if (pay_cnt == pkt_len) begin
              state   <= CSUM;
              dut_inp <= csum;
            end else begin
              dut_inp <= pay_byte;
              csum    <= csum ^ pay_byte;
              pay_cnt <= pay_cnt + 8'd1;
            end
          end
          CSUM: begin
            inp_valid <= 1'b0;
            dut_inp   <= '0;
            if (pkts_sent != 16'hFFFF) pkts_sent <= pkts_sent + 16'd1;
            if (abort_pend || abort_req) begin
              state      <= IDLE;
              abort_pend <= 1'b0;
            end else if (last_pkt) begin
              state    <= IDLE;
              gen_done <= 1'b1;
            end else begin
              state   <= GAP;
              gap_cnt <= (pkt_ipg == 8'd0) ? 8'd1 : pkt_ipg;
            end
          end
          GAP: begin
            if (abort_req)              state   <= IDLE;
            else if (gap_cnt > 8'd1)    gap_cnt <= gap_cnt - 8'd1;
            else                        state   <= WAIT_RDY;
          end
          default: state <= IDLE;
        endcase
      end
      // Aborts during a packet are remembered and honoured once csum is out.
      if (abort_req && (state == HDR || state == LEN || state == PAYLOAD))
        abort_pend <= 1'b1;
    end
  end

endmodule
